// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI4 constants, FSM state types and burst error classification
// for axi_slave_ram.
package axi_pkg;
  localparam int DATA_W = 64;
  localparam int STRB_W = 8;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;
  // Computed in 33 bits so a burst running past 4 GiB cannot wrap back into the window.
  function automatic logic [1:0] burst_err(input logic [31:0] addr, input logic [7:0] len,
                                           input logic [2:0] size, input logic [1:0] burst,
                                           input logic [31:0] base, input logic [32:0] limit);
    logic [32:0] last;
    last = {1'b0, addr} + ({25'd0, len} << size);
    return ({1'b0, addr} < {1'b0, base} || {1'b0, addr} >= limit ||
            (burst == BURST_INCR && last >= limit)) ? RESP_DECERR :
           (burst == BURST_WRAP || burst == 2'b11 || size > 3'd3) ? RESP_SLVERR : RESP_OKAY;
  endfunction
endpackage

// File: rtl/axi_slave_ram_mem.sv
// axi_slave_ram_mem: byte-enable write port plus synchronous read-first read port,
// kept in its own module so synthesis maps it onto block RAM.
module axi_slave_ram_mem
  import axi_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
    for (int b = 0; b < STRB_W; b++)
      if (we && wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
  end
endmodule

// File: rtl/axi_slave_ram.sv
// axi_slave_ram: AXI4 slave exposing a 64-bit RAM window with INCR/FIXED bursts.
// Define AXI_SLAVE_RAM_STALL_EN to add LFSR-driven ready and response stalls.
module axi_slave_ram
  import axi_pkg::*;
#(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_awaddr,
  input  logic [7:0]        s_axi_awlen,
  input  logic [2:0]        s_axi_awsize,
  input  logic [1:0]        s_axi_awburst,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  input  logic [DATA_W-1:0] s_axi_wdata,
  input  logic [STRB_W-1:0] s_axi_wstrb,
  input  logic              s_axi_wlast,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  output logic [1:0]        s_axi_bresp,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  input  logic [31:0]       s_axi_araddr,
  input  logic [7:0]        s_axi_arlen,
  input  logic [2:0]        s_axi_arsize,
  input  logic [1:0]        s_axi_arburst,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rlast
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(DEPTH * 8);
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic live, gate, hold;
  logic [31:0] w_addr, r_addr;
  logic [7:0] w_len, w_cnt, r_len, r_cnt;
  logic [2:0] w_size, r_size;
  logic [1:0] w_burst, w_err, r_burst, r_err;
  logic w_done, aw_hs, w_hs, w_final, ar_hs, r_hs;
  logic [DATA_W-1:0] mem_q;
`ifdef AXI_SLAVE_RAM_STALL_EN
  logic [15:0] lfsr;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) lfsr <= 16'hACE1;
    else lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign gate = lfsr[0];
  assign hold = lfsr[1];
`else
  assign gate = 1'b1;
  assign hold = 1'b0;
`endif
  // Holds every ready low for the first cycle after reset release.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) live <= 1'b0;
    else live <= 1'b1;
  assign s_axi_awready = live && gate && w_state == W_IDLE;
  assign s_axi_wready  = gate && !w_done && w_state == W_DATA;
  assign s_axi_bvalid  = w_state == W_RESP;
  assign s_axi_bresp   = w_err;
  assign aw_hs   = s_axi_awvalid && s_axi_awready;
  assign w_hs    = s_axi_wvalid && s_axi_wready;
  assign w_final = w_hs && w_cnt == w_len;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) w_state <= W_IDLE;
    else w_state <= w_next;
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE: w_next = aw_hs ? W_DATA : W_IDLE;
      W_DATA: w_next = ((w_done || w_final) && !hold) ? W_RESP : W_DATA;
      W_RESP: w_next = s_axi_bready ? W_IDLE : W_RESP;
      default: w_next = W_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      w_addr <= '0;
      w_len <= '0;
      w_size <= '0;
      w_burst <= '0;
      w_err <= RESP_OKAY;
      w_cnt <= '0;
      w_done <= 1'b0;
    end else if (aw_hs) begin
      w_addr <= s_axi_awaddr;
      w_len <= s_axi_awlen;
      w_size <= s_axi_awsize;
      w_burst <= s_axi_awburst;
      w_err <= burst_err(s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, BASE_ADDR, LIMIT);
      w_cnt <= '0;
      w_done <= 1'b0;
    end else if (w_hs) begin
      w_cnt <= w_cnt + 8'd1;
      w_addr <= (w_burst == BURST_FIXED) ? w_addr : w_addr + (32'd1 << w_size);
      w_done <= w_cnt == w_len;
      // A misplaced or missing wlast is a protocol error, but never masks a decode error.
      if (w_err != RESP_DECERR && s_axi_wlast != (w_cnt == w_len)) w_err <= RESP_SLVERR;
    end
  assign s_axi_arready = live && gate && r_state == R_IDLE;
  assign s_axi_rvalid  = r_state == R_DATA;
  assign s_axi_rlast   = s_axi_rvalid && r_cnt == r_len;
  assign s_axi_rresp   = r_err;
  assign s_axi_rdata   = (s_axi_rvalid && r_err == RESP_OKAY) ? mem_q : '0;
  assign ar_hs = s_axi_arvalid && s_axi_arready;
  assign r_hs  = s_axi_rvalid && s_axi_rready;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= R_IDLE;
    else r_state <= r_next;
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  r_next = ar_hs ? R_FETCH : R_IDLE;
      R_FETCH: r_next = hold ? R_FETCH : R_DATA;
      R_DATA:  r_next = r_hs ? (s_axi_rlast ? R_IDLE : R_FETCH) : R_DATA;
      default: r_next = R_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_addr <= '0;
      r_len <= '0;
      r_size <= '0;
      r_burst <= '0;
      r_err <= RESP_OKAY;
      r_cnt <= '0;
    end else if (ar_hs) begin
      r_addr <= s_axi_araddr;
      r_len <= s_axi_arlen;
      r_size <= s_axi_arsize;
      r_burst <= s_axi_arburst;
      r_err <= burst_err(s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, BASE_ADDR, LIMIT);
      r_cnt <= '0;
    end else if (r_hs && !s_axi_rlast) begin
      r_cnt <= r_cnt + 8'd1;
      r_addr <= (r_burst == BURST_FIXED) ? r_addr : r_addr + (32'd1 << r_size);
    end
  axi_slave_ram_mem #(.DEPTH(DEPTH)) u_mem (
    .clk(i_clk),
    .we(w_hs && w_err == RESP_OKAY),
    .waddr(w_addr[AW+2:3]),
    .wdata(s_axi_wdata),
    .wstrb(s_axi_wstrb),
    .re(r_state == R_FETCH),
    .raddr(r_addr[AW+2:3]),
    .rdata(mem_q)
  );
endmodule

// File: tb/tb_axi_slave_ram.sv
// tb_axi_slave_ram: directed bursts against axi_slave_ram; expected B/R responses
// are queued at issue time and checked by a monitor on each handshake.
module tb_axi_slave_ram;
  import axi_pkg::*;
  logic i_clk = 1'b0, i_rst_n = 1'b0;
  logic s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready, s_axi_wlast;
  logic s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic s_axi_rvalid, s_axi_rready, s_axi_rlast;
  logic [31:0] s_axi_awaddr, s_axi_araddr;
  logic [7:0] s_axi_awlen, s_axi_arlen, s_axi_wstrb;
  logic [2:0] s_axi_awsize, s_axi_arsize;
  logic [1:0] s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
  logic [63:0] s_axi_wdata, s_axi_rdata;
  typedef struct { logic [63:0] d; logic [1:0] resp; logic last; } rexp_t;
  rexp_t exp_r[$];
  rexp_t e;
  logic [1:0] exp_b[$];
  logic [63:0] wd[$];
  int n_chk = 0, n_fail = 0;
  bit exp_bubble = 0;
  axi_slave_ram dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
    .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr),
    .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic fail(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event missing or unexpected", nm);
  endtask
  always @(negedge i_clk) begin
    if (exp_bubble) chk("r_bubble", 64'(s_axi_rvalid), 64'd0);
    exp_bubble = 0;
    if (s_axi_bvalid && s_axi_bready) begin
      if (exp_b.size() == 0) fail("b_unexpected");
      else chk("bresp", 64'(s_axi_bresp), 64'(exp_b.pop_front()));
    end
    if (s_axi_rvalid && s_axi_rready) begin
      if (exp_r.size() == 0) fail("r_unexpected");
      else begin
        e = exp_r.pop_front();
        chk("rdata", s_axi_rdata, e.d);
        chk("rresp", 64'(s_axi_rresp), 64'(e.resp));
        chk("rlast", 64'(s_axi_rlast), 64'(e.last));
      end
      exp_bubble = !s_axi_rlast;
    end
  end
  task automatic wait_rdy(input int k);
    bit hs = 0;
    int n = 0;
    while (!hs && n < 50) begin
      @(negedge i_clk);
      hs = (k == 0) ? s_axi_awready : (k == 1) ? s_axi_wready : s_axi_arready;
      @(posedge i_clk); #1;
      n++;
    end
    if (!hs) fail($sformatf("ready_timeout_ch%0d", k));
  endtask
  task automatic drain();
    int n = 0;
    while ((exp_b.size() != 0 || exp_r.size() != 0) && n < 200) begin
      @(posedge i_clk); #1;
      n++;
    end
    if (exp_b.size() != 0 || exp_r.size() != 0) begin
      fail("drain_timeout");
      exp_b.delete();
      exp_r.delete();
    end
  endtask
  task automatic zero_ram();
    @(negedge i_clk);
    for (int i = 0; i < 256; i++) dut.u_mem.mem[i] <= '0;
    @(posedge i_clk); #1;
  endtask
  task automatic push_r(input logic [63:0] d, input logic [1:0] resp, input logic last);
    rexp_t x;
    x.d = d;
    x.resp = resp;
    x.last = last;
    exp_r.push_back(x);
  endtask
  task automatic do_write(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [7:0] strb, input int wl,
                          input logic [1:0] resp, input int bd);
    int n = 0;
    exp_b.push_back(resp);
    s_axi_awaddr = a;
    s_axi_awlen = len;
    s_axi_awsize = size;
    s_axi_awburst = burst;
    s_axi_awvalid = 1;
    wait_rdy(0);
    s_axi_awvalid = 0;
    for (int i = 0; i <= int'(len); i++) begin
      s_axi_wdata = wd[i];
      s_axi_wstrb = strb;
      s_axi_wlast = (i == wl);
      s_axi_wvalid = 1;
      wait_rdy(1);
    end
    s_axi_wvalid = 0;
    s_axi_wlast = 0;
    if (bd > 0) begin
      while (!s_axi_bvalid && n < 50) begin @(negedge i_clk); n++; end
      repeat (bd) begin
        @(negedge i_clk);
        chk("b_hold_valid", 64'(s_axi_bvalid), 64'd1);
        chk("b_hold_resp", 64'(s_axi_bresp), 64'(resp));
        chk("b_hold_awready", 64'(s_axi_awready), 64'd0);
      end
      @(posedge i_clk); #1;
    end
    s_axi_bready = 1;
    drain();
    s_axi_bready = 0;
  endtask
  task automatic do_read(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input int rd);
    int n = 0;
    s_axi_araddr = a;
    s_axi_arlen = len;
    s_axi_arsize = size;
    s_axi_arburst = burst;
    s_axi_arvalid = 1;
    wait_rdy(2);
    s_axi_arvalid = 0;
    if (rd > 0 && exp_r.size() != 0) begin
      while (!s_axi_rvalid && n < 50) begin @(negedge i_clk); n++; end
      repeat (rd) begin
        @(negedge i_clk);
        chk("r_hold_valid", 64'(s_axi_rvalid), 64'd1);
        chk("r_hold_data", s_axi_rdata, exp_r[0].d);
        chk("r_hold_last", 64'(s_axi_rlast), 64'(exp_r[0].last));
      end
      @(posedge i_clk); #1;
    end
    s_axi_rready = 1;
    drain();
    s_axi_rready = 0;
  endtask
  initial begin
    int n;
    {s_axi_awvalid, s_axi_wvalid, s_axi_wlast, s_axi_bready, s_axi_arvalid, s_axi_rready} = '0;
    {s_axi_awaddr, s_axi_araddr, s_axi_awlen, s_axi_arlen, s_axi_wstrb} = '0;
    {s_axi_awsize, s_axi_arsize, s_axi_awburst, s_axi_arburst, s_axi_wdata} = '0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_awready", 64'(s_axi_awready), 64'd0);
    chk("rst_wready", 64'(s_axi_wready), 64'd0);
    chk("rst_arready", 64'(s_axi_arready), 64'd0);
    chk("rst_bvalid", 64'(s_axi_bvalid), 64'd0);
    chk("rst_rvalid", 64'(s_axi_rvalid), 64'd0);
    chk("rst_rlast", 64'(s_axi_rlast), 64'd0);
    chk("rst_bresp", 64'(s_axi_bresp), 64'd0);
    chk("rst_rresp", 64'(s_axi_rresp), 64'd0);
    chk("rst_rdata", s_axi_rdata, 64'd0);
    @(posedge i_clk); #1;
    i_rst_n = 1;
    repeat (2) @(posedge i_clk); #1;
    zero_ram();
    wd = '{64'h1122334455667788};
    do_write(32'h1000_0000, 0, 3, BURST_INCR, 8'hFF, 0, RESP_OKAY, 0);
    wd = '{64'h0000_0000_00AA_0000};
    do_write(32'h1000_0002, 0, 0, BURST_INCR, 8'h04, 0, RESP_OKAY, 0);
    push_r(64'h11223344_55AA7788, RESP_OKAY, 1);
    do_read(32'h1000_0000, 0, 3, BURST_INCR, 0);
    zero_ram();
    wd = '{64'd1, 64'd2, 64'd3, 64'd4};
    do_write(32'h1000_0010, 3, 3, BURST_INCR, 8'hFF, 3, RESP_OKAY, 0);
    for (int i = 1; i <= 4; i++) push_r(64'(i), RESP_OKAY, i == 4);
    do_read(32'h1000_0010, 3, 3, BURST_INCR, 0);
    zero_ram();
    wd = '{64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB};
    do_write(32'h2000_0000, 1, 3, BURST_INCR, 8'hFF, 1, RESP_DECERR, 0);
    chk("decerr_ram0", dut.u_mem.mem[0], 64'd0);
    chk("decerr_ram1", dut.u_mem.mem[1], 64'd0);
    push_r(64'd0, RESP_DECERR, 0);
    push_r(64'd0, RESP_DECERR, 1);
    do_read(32'h1000_07F8, 1, 3, BURST_INCR, 0);
    zero_ram();
    wd = '{64'h5555, 64'h6666};
    do_write(32'h1000_0000, 0, 3, BURST_WRAP, 8'hFF, 0, RESP_SLVERR, 0);
    push_r(64'd0, RESP_SLVERR, 1);
    do_read(32'h1000_0000, 0, 4, BURST_INCR, 0);
    do_write(32'h1000_0020, 1, 3, BURST_INCR, 8'hFF, 0, RESP_SLVERR, 0);
    zero_ram();
    wd = '{64'hCAFE_F00D_DEAD_BEEF};
    do_write(32'h1000_0030, 0, 3, BURST_INCR, 8'hFF, 0, RESP_OKAY, 4);
    push_r(64'hCAFE_F00D_DEAD_BEEF, RESP_OKAY, 1);
    do_read(32'h1000_0030, 0, 3, BURST_INCR, 5);
    wd = '{64'd5, 64'd6, 64'd7, 64'd8};
    do_write(32'h1000_0040, 3, 3, BURST_INCR, 8'hFF, 3, RESP_OKAY, 0);
    s_axi_araddr = 32'h1000_0040;
    s_axi_arlen = 3;
    s_axi_arsize = 3;
    s_axi_arburst = BURST_INCR;
    s_axi_arvalid = 1;
    wait_rdy(2);
    s_axi_arvalid = 0;
    n = 0;
    while (!s_axi_rvalid && n < 50) begin @(negedge i_clk); n++; end
    if (!s_axi_rvalid) fail("rvalid_before_reset");
    i_rst_n = 0;
    #1;
    chk("mid_rst_rvalid", 64'(s_axi_rvalid), 64'd0);
    chk("mid_rst_rlast", 64'(s_axi_rlast), 64'd0);
    chk("mid_rst_arready", 64'(s_axi_arready), 64'd0);
    @(posedge i_clk); #1;
    i_rst_n = 1;
    @(negedge i_clk);
    chk("post_rst_arready0", 64'(s_axi_arready), 64'd0);
    @(negedge i_clk);
    chk("post_rst_arready1", 64'(s_axi_arready), 64'd1);
    @(posedge i_clk); #1;
    for (int i = 5; i <= 8; i++) push_r(64'(i), RESP_OKAY, i == 8);
    do_read(32'h1000_0040, 3, 3, BURST_INCR, 0);
    repeat (3) @(posedge i_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/axi_slave_ram.md
Name: axi_slave_ram

Overview:
- AXI4 memory-mapped slave that sits directly downstream of simple_axi_master; it is the synthesizable target behind the master's AW/W/B/AR/R channels.
- Implements a 64-bit-wide on-chip RAM window with byte-strobe writes, INCR/FIXED bursts and OKAY/SLVERR/DECERR responses.
- Write and read channels run as independent FSMs sharing one dual-port RAM.

Parameters:
- DEPTH, 256: number of 64-bit words; power of two.
- BASE_ADDR, 32'h1000_0000: window base; must be aligned to DEPTH*8.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- s_axi_awvalid / s_axi_awready  in/out  1  AW handshake.
- s_axi_awaddr  in  32  write start byte address.
- s_axi_awlen  in  8  beats-1.
- s_axi_awsize  in  3  log2 bytes per beat.
- s_axi_awburst  in  2  burst type.
- s_axi_wvalid / s_axi_wready  in/out  1  W handshake.
- s_axi_wdata  in  64  write data.
- s_axi_wstrb  in  8  byte enables.
- s_axi_wlast  in  1  last write beat.
- s_axi_bvalid / s_axi_bready  out/in  1  B handshake.
- s_axi_bresp  out  2  write response.
- s_axi_arvalid / s_axi_arready  in/out  1  AR handshake.
- s_axi_araddr  in  32  read start address.
- s_axi_arlen  in  8  read beats-1.
- s_axi_arsize  in  3  read beat size.
- s_axi_arburst  in  2  read burst type.
- s_axi_rvalid / s_axi_rready  out/in  1  R handshake.
- s_axi_rdata  out  64  read data.
- s_axi_rresp  out  2  read response.
- s_axi_rlast  out  1  last read beat.

Behaviour:
- Reset (asynchronous, i_rst_n low): both FSMs go to IDLE. All readies, bvalid, rvalid and rlast = 0. bresp, rresp and rdata = 0. RAM contents are not reset.
- Write FSM, W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1. On AW handshake, latch addr/len/size/burst, compute the error code, clear the beat counter.
  - W_DATA: wready=1. Each W handshake writes the strobed bytes to word addr[idx+2:3] unless an error code is latched.
  - Address step: INCR adds 1<<size to the byte address; FIXED holds it.
  - The burst ends when the counter reaches len, not on wlast. wlast asserted on any other beat, or absent on the final beat, forces SLVERR (unless DECERR is already latched).
  - W_RESP: bvalid=1 with bresp, held stable until bready; then return to W_IDLE.
  - AW handshake to first wready: 1 cycle. Last W handshake to bvalid: 1 cycle.
- Read FSM, R_IDLE -> R_FETCH -> R_DATA:
  - R_IDLE: arready=1. Latch fields and compute the error code as for writes.
  - R_FETCH: issue a synchronous RAM read.
  - R_DATA: rvalid=1; rdata is the full 64-bit word (the master extracts lanes); rlast=1 on beat len.
  - rvalid, rdata, rresp and rlast stay stable until rready. After a non-final handshake, step the address and go to R_FETCH, giving a 1-cycle rvalid bubble between beats.
  - First rvalid appears 2 cycles after the AR handshake.
- Error codes, checked at address acceptance (priority DECERR > SLVERR):
  - DECERR (2'b11): start address, or end address start+(len<<size) for INCR, lies outside [BASE_ADDR, BASE_ADDR+DEPTH*8).
  - SLVERR (2'b10): burst is WRAP or reserved, or size>3.
  - On error, writes are suppressed but all len+1 beats are still consumed; reads return rdata=0 for all len+1 beats, each with rresp=error.
- Same-word read and write in the same cycle: the read returns the old data (read-first).
- Reset asserted mid-burst: the burst is abandoned; bytes already written stay in RAM.

Optional Feature:
- AXI_SLAVE_RAM_STALL_EN defined: a 16-bit LFSR (seed 16'hACE1, advances every cycle) gates awready, wready and arready with bit 0. Entry to R_DATA and W_RESP is delayed while bit 1 is 1.
- Once asserted, valids are never withdrawn before their handshake.
- Undefined: no stalls; latencies exactly as stated in Behaviour.

Decomposition:
- Package axi_pkg:
  - BURST_FIXED/INCR/WRAP constants.
  - RESP_OKAY/EXOKAY/SLVERR/DECERR constants.
  - Write and read FSM state enums.
  - DATA_W=64, STRB_W=8.
- Sub-module axi_slave_ram_mem: one byte-enable write port, one synchronous read port, read-first; kept separate for BRAM inference.

Test Plan:
- The bench backdoor-zeroes the RAM before each scenario.
- Byte strobe write: AW 0x1000_0000 size 3 len 0, wdata 0x1122334455667788 strb 0xFF. Then AW 0x1000_0002 size 0, wdata 0x0000_0000_00AA_0000 strb 0x04 -> both bresp 00. Read 0x1000_0000 size 3 -> 0x11223344_55AA7788, rlast=1, rresp 00.
- INCR len 3 size 3 at 0x1000_0010, data 1,2,3,4, wlast on 4th beat -> bresp 00. Read the same burst -> rdata 1,2,3,4 with one-cycle rvalid bubbles; rlast only on beat 4.
- Write to 0x2000_0000 len 1 -> both beats accepted, bresp 11, RAM unchanged. Read 0x1000_07F8 len 1 (end out of window) -> 2 beats, rdata 0, rresp 11.
- awburst=2'b10 -> bresp 10. arsize=4 -> rresp 10. wlast on beat 0 of len 1 -> bresp 10.
- Backpressure: bready low 4 cycles -> bvalid/bresp stable and awready 0 until the B handshake. rready low 5 cycles -> rvalid/rdata/rlast stable.
- i_rst_n pulsed low mid read burst -> rvalid=0 immediately; arready=1 one cycle after release. A new read returns the correct data.
